// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store handshake: accepts one-cycle
// read/write pulses and performs a sized, byte-lane access after a fixed latency.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RREQ,
   input  logic        CWE,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   input  logic [2:0]  LIM,
   input  logic        SIGNED,
   output logic [31:0] RDATA,
   output logic        RDY,
   output logic        MISALIGN
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       accept;
   logic       complete;

   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        lim_q;
   logic              sgn_q;
   logic              wr_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic              is_byte;
   logic              is_half;
   logic              mis;
   logic [31:0]       cur;
   logic [3:0]        be;
   logic [31:0]       wd;
   logic [31:0]       merged;
   logic [31:0]       rd_ext;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;

   // Address bits above the word index wrap and carry no meaning here.
   logic unused_addr;
   assign unused_addr = ^ADDR[31:ADDR_W+2];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      complete  = 1'b0;
      RDY       = (state == IDLE);
      case (state)
         IDLE: begin
            if (RREQ || CWE) begin
               accept    = 1'b1;
               cnt_nxt   = 4'(LATENCY - 1);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q  <= '0;
         wdata_q <= '0;
         lim_q   <= '0;
         sgn_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= ADDR[ADDR_W+1:0];
         wdata_q <= WDATA;
         lim_q   <= LIM;
         sgn_q   <= SIGNED;
         wr_q    <= CWE;
      end
   end

   always_comb begin
      idx     = addr_q[ADDR_W+1:2];
      lane    = addr_q[1:0];
      is_byte = (lim_q == 3'd0);
      is_half = (lim_q == 3'd1);
      mis     = is_half ? lane[0] : (!is_byte && (lane != 2'd0));
      cur     = mem[idx];

      // Write data is replicated across lanes so the byte enables alone pick placement.
      if (is_byte) begin
         be = 4'b0001 << lane;
         wd = {4{wdata_q[7:0]}};
      end else if (is_half) begin
         be = lane[1] ? 4'b1100 : 4'b0011;
         wd = {2{wdata_q[15:0]}};
      end else begin
         be = 4'b1111;
         wd = wdata_q;
      end

      merged = cur;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = wd[8*i +: 8];
         end
      end

      rd_byte = cur[{lane, 3'b000} +: 8];
      rd_half = lane[1] ? cur[31:16] : cur[15:0];
      if (is_byte) begin
         rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      end else if (is_half) begin
         rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
      end else begin
         rd_ext = cur;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         RDATA    <= '0;
         MISALIGN <= 1'b0;
      end else if (complete) begin
         MISALIGN <= mis;
         if (!wr_q) begin
            RDATA <= mis ? '0 : rd_ext;
         end
      end
   end

   // Array is deliberately outside reset; reset only blocks an in-flight write.
   always_ff @(posedge CLK) begin
      if (!RST && complete && wr_q && !mis) begin
         mem[idx] <= merged;
      end
   end

endmodule
